sccb_write_master: RTL and testbench

//   Write-only SCCB/I2C master used by the camera-config sequencer to send one register write per request.

---
 rtl/sccb_write_master_pkg.sv | 15 +
 rtl/sccb_write_master_if.sv | 8 +
 rtl/sccb_write_master_qtick.sv | 21 ++
 rtl/sccb_write_master.sv | 67 ++++++
 tb/tb_sccb_write_master.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sccb_write_master_pkg.sv
// sccb_write_master_pkg: camera IDs, FSM state encoding and per-quarter {SCL,SDA} patterns shared by the SCCB write master
package sccb_write_master_pkg;
  localparam logic [7:0] SCCB_OV2640 = 8'h60;
  localparam logic [7:0] SCCB_OV5640 = 8'h78;
  localparam logic [1:0] Q_STA0 = 2'd2;
  typedef enum logic [2:0] {IDLE, STA, BIT, ACK, STO} state_t;
  function automatic logic [1:0] bus_pat(input state_t st, input logic [1:0] q, input logic d);
    return st == IDLE ? 2'b11 :
           st == STA  ? {1'b1, q != 2'd3} :
                        {q[1], st == BIT ? d : st == ACK ? 1'b1 : q == 2'd3};
  endfunction
  function automatic int byte_count(input int regi_msb);
    return regi_msb == 15 ? 4 : 3;
  endfunction
endpackage

// File: rtl/sccb_write_master_if.sv
// sccb_write_master_if: request (regi/regv/start -> done/nack) and pad (sda_i -> sda_o/scl_o) signals of the SCCB write master
interface sccb_write_master_if #(parameter int REGI_MSB = 15) ();
  logic [REGI_MSB:0] regi;
  logic [7:0] regv;
  logic start, done, nack, sda_i, sda_o, scl_o;
  modport master (input regi, regv, start, sda_i, output done, nack, sda_o, scl_o);
  modport slave (output regi, regv, start, sda_i, input done, nack, sda_o, scl_o);
endinterface

// File: rtl/sccb_write_master_qtick.sv
// sccb_write_master_qtick: enabled prescaler; in clk/reset/en, out tick (1 clk every 2^W clk) and q (quarter index, parked at 2 so START fills quarters 2..3)
module sccb_write_master_qtick import sccb_write_master_pkg::*; #(
  parameter int W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       tick,
  output logic [1:0] q
);
  logic [W-1:0] cnt;
  assign tick = en && &cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset || !en) begin
      cnt <= '0;
      q   <= Q_STA0;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) q <= q + 2'd1;
    end
endmodule

// File: rtl/sccb_write_master.sv
// sccb_write_master: one SCCB register write per start (START, ID, index, value, STOP); ports clk, reset, bus (regi/regv/start/done/nack/sda_i/sda_o/scl_o)
module sccb_write_master import sccb_write_master_pkg::*; #(
  parameter logic [7:0] TARGET_ID    = SCCB_OV5640,
  parameter int         REGI_MSB     = 15,
  parameter int         CLK_DIV_LOG2 = 8
) (
  input logic clk,
  input logic reset,
  sccb_write_master_if.master bus
);
  localparam int W = REGI_MSB + 17;
  localparam logic [1:0] LAST = 2'(byte_count(REGI_MSB) - 1);
  state_t state;
  logic [W-1:0] sh;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt, q;
  logic tick;
  sccb_write_master_qtick #(.W(CLK_DIV_LOG2 - 2)) u_qtick (
    .clk(clk), .reset(reset), .en(state != IDLE), .tick(tick), .q(q)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      sh         <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      bus.done   <= 1'b1;
      bus.nack   <= 1'b0;
      bus.scl_o  <= 1'b1;
      bus.sda_o  <= 1'b1;
    end else if (state == IDLE) begin
      if (bus.start) begin
        sh       <= {TARGET_ID & 8'hfe, bus.regi, bus.regv};
        state    <= STA;
        bus.done <= 1'b0;
        bus.nack <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end
    end else if (tick) begin
      {bus.scl_o, bus.sda_o} <= bus_pat(state, q + 2'd1, sh[W-1]);
      if (state == ACK && q == 2'd2) bus.nack <= bus.nack | bus.sda_i;
      if (q == 2'd3)
        case (state)
          STA: begin
            state <= BIT;
            {bus.scl_o, bus.sda_o} <= bus_pat(BIT, 2'd0, sh[W-1]);
          end
          BIT: begin
            sh      <= sh << 1;
            bit_cnt <= bit_cnt + 3'd1;
            state   <= bit_cnt == 3'd7 ? ACK : BIT;
            {bus.scl_o, bus.sda_o} <= bus_pat(bit_cnt == 3'd7 ? ACK : BIT, 2'd0, sh[W-2]);
          end
          ACK: begin
            byte_cnt <= byte_cnt + 2'd1;
            state    <= byte_cnt == LAST ? STO : BIT;
            {bus.scl_o, bus.sda_o} <= bus_pat(byte_cnt == LAST ? STO : BIT, 2'd0, sh[W-1]);
          end
          default: begin
            state    <= IDLE;
            bus.done <= 1'b1;
            {bus.scl_o, bus.sda_o} <= 2'b11;
          end
        endcase
    end
endmodule

// File: tb/tb_sccb_write_master.sv
// tb_sccb_write_master: scoreboard bench decoding the SCCB bus of a 2-index-byte and a 1-index-byte instance
module tb_sccb_write_master;
  import sccb_write_master_pkg::*;
  typedef struct {
    logic [31:0] b;
    int nb;
    logic nack;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  logic pscl[2], psda[2], pdone[2];
  logic busy[2], in_frame[2];
  int bitn[2], nbytes[2], t0[2];
  logic [8:0] shf[2];
  logic [7:0] got[2][4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sccb_write_master_if #(.REGI_MSB(15)) if0 ();
  sccb_write_master_if #(.REGI_MSB(7)) if1 ();
  sccb_write_master #(.TARGET_ID(SCCB_OV5640), .REGI_MSB(15), .CLK_DIV_LOG2(4)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  sccb_write_master #(.TARGET_ID(SCCB_OV2640), .REGI_MSB(7), .CLK_DIV_LOG2(4)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic bad(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask
  function automatic exp_t mk(input int d, input logic [15:0] ri, input logic [7:0] rv, input logic nk);
    exp_t e;
    e.b    = d == 0 ? {8'h78, ri, rv} : {8'h60, ri[7:0], rv, 8'h00};
    e.nb   = d == 0 ? 4 : 3;
    e.lat  = d == 0 ? 600 : 456;
    e.nack = nk;
    return e;
  endfunction
  task automatic wr(input int d, input logic [15:0] ri, input logic [7:0] rv, input logic al, input logic nk);
    if (d == 0) begin
      q0.push_back(mk(0, ri, rv, nk));
      if0.regi = ri; if0.regv = rv; if0.sda_i = al; if0.start = 1'b1;
    end else begin
      q1.push_back(mk(1, ri, rv, nk));
      if1.regi = ri[7:0]; if1.regv = rv; if1.sda_i = al; if1.start = 1'b1;
    end
    @(posedge clk); #1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    chk("accept_done", d == 0 ? if0.done : if1.done, 0);
    chk("accept_nack", d == 0 ? if0.nack : if1.nack, 0);
  endtask
  task automatic wait_level(input int d, input logic lvl);
    int n = 0;
    while ((d == 0 ? if0.done : if1.done) !== lvl && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) bad($sformatf("wait_done%0d_timeout", d));
  endtask
  initial begin
    logic scl, sda, dn, nk;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        scl = d == 0 ? if0.scl_o : if1.scl_o;
        sda = d == 0 ? if0.sda_o : if1.sda_o;
        dn  = d == 0 ? if0.done : if1.done;
        nk  = d == 0 ? if0.nack : if1.nack;
        if (reset) begin
          busy[d] = 1'b0;
          in_frame[d] = 1'b0;
        end else begin
          if (pdone[d] && !dn) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) bad("unexpected_accept");
            else begin
              cur[d] = d == 0 ? q0.pop_front() : q1.pop_front();
              busy[d] = 1'b1;
              t0[d] = cyc;
            end
          end
          if (!pdone[d] && dn && busy[d]) begin
            chk("latency", cyc - t0[d], cur[d].lat);
            chk("nack", nk, cur[d].nack);
            busy[d] = 1'b0;
          end
          if (scl && pscl[d] && psda[d] && !sda) begin
            if (in_frame[d]) bad("start_inside_frame");
            in_frame[d] = 1'b1;
            bitn[d] = 0;
            nbytes[d] = 0;
          end else if (scl && pscl[d] && !psda[d] && sda) begin
            if (!in_frame[d] || !busy[d]) bad("stray_stop");
            else begin
              chk("stop_align", bitn[d], 1);
              chk("byte_count", nbytes[d], cur[d].nb);
              for (int k = 0; k < nbytes[d] && k < 4; k++)
                chk($sformatf("dut%0d_byte%0d", d, k), got[d][k], cur[d].b[31-8*k -: 8]);
            end
            in_frame[d] = 1'b0;
          end else if (scl && !pscl[d] && in_frame[d]) begin
            shf[d] = {shf[d][7:0], sda};
            bitn[d]++;
            if (bitn[d] == 9) begin
              if (nbytes[d] < 4) got[d][nbytes[d]] = shf[d][8:1];
              chk("ack_released", shf[d][0], 1);
              nbytes[d]++;
              bitn[d] = 0;
            end
          end
        end
        pscl[d] = scl;
        psda[d] = sda;
        pdone[d] = dn;
      end
    end
  end
  initial begin
    int n;
    if0.start = 1'b0; if0.regi = '0; if0.regv = '0; if0.sda_i = 1'b0;
    if1.start = 1'b0; if1.regi = '0; if1.regv = '0; if1.sda_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_done", if0.done, 1);
    chk("rst_nack", if0.nack, 0);
    chk("rst_sda", if0.sda_o, 1);
    chk("rst_scl", if0.scl_o, 1);
    chk("rst_done1", if1.done, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    wr(0, 16'h3008, 8'h82, 1'b0, 1'b0);
    wait_level(0, 1'b1);
    wr(1, 16'h0012, 8'h80, 1'b0, 1'b0);
    wait_level(1, 1'b1);
    wr(0, 16'h3a00, 8'h11, 1'b1, 1'b1);
    wait_level(0, 1'b1);
    wr(0, 16'h3103, 8'h03, 1'b0, 1'b0);
    wait_level(0, 1'b1);
    wr(0, 16'h4300, 8'h30, 1'b0, 1'b0);
    repeat (100) @(posedge clk); #1;
    if0.start = 1'b1; if0.regi = 16'hffff; if0.regv = 8'h00;
    @(posedge clk); #1;
    if0.start = 1'b0;
    chk("no_restart", if0.done, 0);
    wait_level(0, 1'b1);
    wr(0, 16'h1234, 8'h56, 1'b0, 1'b0);
    repeat (345) @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_sda", if0.sda_o, 1);
    chk("abort_scl", if0.scl_o, 1);
    chk("abort_done", if0.done, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    wr(0, 16'h5678, 8'h9a, 1'b0, 1'b0);
    wait_level(0, 1'b1);
    q0.push_back(mk(0, 16'h3017, 8'h5a, 1'b0));
    q0.push_back(mk(0, 16'h3017, 8'h5a, 1'b0));
    if0.regi = 16'h3017; if0.regv = 8'h5a; if0.sda_i = 1'b0; if0.start = 1'b1;
    wait_level(0, 1'b0);
    wait_level(0, 1'b1);
    n = 0;
    while (if0.done === 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_idle_clks", n, 1);
    if0.start = 1'b0;
    wait_level(0, 1'b1);
    repeat (5) @(posedge clk); #1;
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
